// File: rtl/jacobi_pivot_search.sv
// jacobi_pivot_search: scans the strict upper triangle of an NxN symmetric
// matrix and reports the off-diagonal element of largest magnitude (p,q,M_pq).
// Optional convergence flag is built only when PIVOT_THRESH_EN is defined;
// otherwise converged is tied 0 and THRESH is unused.
module jacobi_pivot_search #(
    parameter int              N      = 4,
    parameter int              IDX_W  = 2,
    parameter int              DW     = 32,
    parameter logic [DW-1:0]   THRESH = 32'h3727C5AC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_i,
    output logic [IDX_W-1:0] rd_j,
    input  logic [DW-1:0]    M_ij,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] pivot_p,
    output logic [IDX_W-1:0] pivot_q,
    output logic [DW-1:0]    pivot_val,
    output logic             converged
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N - 2);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    // issued index delayed to line up with the returned data
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] vi_q, vi_d, vj_q, vj_d;
    // running maximum
    logic             first_q, first_d;
    logic [DW-1:0]    max_val_q, max_val_d;
    logic [IDX_W-1:0] max_p_q, max_p_d, max_q_q, max_q_d;
    // published results
    logic [IDX_W-1:0] pivot_p_q, pivot_p_d, pivot_q_q, pivot_q_d;
    logic [DW-1:0]    pivot_val_q, pivot_val_d;
    logic             take;

    // Next-state, scan address generation and output decode
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    i_d     = '0;
                    j_d     = ONE;
                end
            end
            S_SCAN: begin
                if (j_q == LAST_J) begin
                    if (i_q == LAST_I) begin
                        // last element issued; park the address at 0
                        state_d = S_DRAIN;
                        i_d     = '0;
                        j_d     = '0;
                    end else begin
                        i_d = i_q + ONE;
                        j_d = i_q + ONE + ONE;
                    end
                end else begin
                    j_d = j_q + ONE;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_en = (state_q == S_SCAN);
    assign rd_i  = i_q;
    assign rd_j  = j_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);

    // Magnitude compare on the returned element; sign bit ignored, so +0 == -0
    // and Inf/NaN naturally rank highest. Strict greater keeps the earliest tie.
    always_comb begin
        vld_d     = rd_en;
        vi_d      = i_q;
        vj_d      = j_q;
        first_d   = first_q;
        max_val_d = max_val_q;
        max_p_d   = max_p_q;
        max_q_d   = max_q_q;
        take      = vld_q && (first_q || (M_ij[DW-2:0] > max_val_q[DW-2:0]));
        if (vld_q) first_d = 1'b0;
        if (take) begin
            max_val_d = M_ij;
            max_p_d   = vi_q;
            max_q_d   = vj_q;
        end
        if (state_q == S_IDLE && start) begin
            first_d   = 1'b1;
            max_val_d = '0;
            max_p_d   = '0;
            max_q_d   = '0;
        end
    end

    // Results are loaded on the DRAIN->DONE edge (including the final
    // compare) so they are visible in the DONE cycle and hold afterwards.
    always_comb begin
        pivot_p_d   = pivot_p_q;
        pivot_q_d   = pivot_q_q;
        pivot_val_d = pivot_val_q;
        if (state_q == S_DRAIN) begin
            pivot_p_d   = max_p_d;
            pivot_q_d   = max_q_d;
            pivot_val_d = max_val_d;
        end
    end

    // State, address, pipeline and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            vld_q       <= 1'b0;
            vi_q        <= '0;
            vj_q        <= '0;
            first_q     <= 1'b0;
            max_val_q   <= '0;
            max_p_q     <= '0;
            max_q_q     <= '0;
            pivot_p_q   <= '0;
            pivot_q_q   <= '0;
            pivot_val_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            vld_q       <= vld_d;
            vi_q        <= vi_d;
            vj_q        <= vj_d;
            first_q     <= first_d;
            max_val_q   <= max_val_d;
            max_p_q     <= max_p_d;
            max_q_q     <= max_q_d;
            pivot_p_q   <= pivot_p_d;
            pivot_q_q   <= pivot_q_d;
            pivot_val_q <= pivot_val_d;
        end
    end

    assign pivot_p   = pivot_p_q;
    assign pivot_q   = pivot_q_q;
    assign pivot_val = pivot_val_q;

`ifdef PIVOT_THRESH_EN
    logic converged_q, converged_d;

    // Convergence flag tracks the pivot outputs: loaded with them, held with them
    always_comb begin
        converged_d = converged_q;
        if (state_q == S_DRAIN)
            converged_d = (max_val_d[DW-2:0] < THRESH[DW-2:0]);
    end

    // Convergence flag register
    always_ff @(posedge clk) begin
        if (reset) converged_q <= 1'b0;
        else       converged_q <= converged_d;
    end

    assign converged = converged_q;
`else
    assign converged = 1'b0;
`endif

endmodule
